// File: rtl/encoder_channel_ctrl.sv
// encoder_channel_ctrl: routes encoder inc/dec steps to one of three RGB
// channel levels. A debounced push-button cycles the active channel R->G->B.
module encoder_channel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,   // 1..65535
    parameter int STEP            = 1,   // 1..255
    parameter bit SATURATE        = 1'b1 // 1 = clamp, 0 = wrap mod 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       btn,
    output logic [1:0] sel,
    output logic [7:0] value_r,
    output logic [7:0] value_g,
    output logic [7:0] value_b,
    output logic       updated
);

    localparam logic [1:0]  SEL_R    = 2'd0;
    localparam logic [1:0]  SEL_G    = 2'd1;
    localparam logic [1:0]  SEL_B    = 2'd2;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [8:0]  STEP9    = 9'(STEP);

    logic        btn_s1, btn_s2;
    logic        btn_deb;
    logic [15:0] deb_cnt;
    logic        press;
    logic [7:0]  cur;
    logic [8:0]  up9, dn9;
    logic [7:0]  nxt;

    // Debounced level is about to rise on this edge: that is the press event.
    assign press = btn_s2 && !btn_deb && (deb_cnt == CNT_LAST);

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_deb <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s2 == btn_deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            btn_deb <= btn_s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    // Channel select FSM; advances once per press, release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= SEL_R;
        end else if (press) begin
            case (sel)
                SEL_R:   sel <= SEL_G;
                SEL_G:   sel <= SEL_B;
                default: sel <= SEL_R;
            endcase
        end
    end

    // Next value of the currently selected channel (9-bit to catch carry/borrow).
    always_comb begin
        case (sel)
            SEL_G:   cur = value_g;
            SEL_B:   cur = value_b;
            default: cur = value_r;
        endcase
        up9 = {1'b0, cur} + STEP9;
        dn9 = {1'b0, cur} - STEP9;
        nxt = cur;
        if (inc && !dec)
            nxt = (SATURATE && up9[8]) ? 8'hFF : up9[7:0];
        else if (dec && !inc)
            nxt = (SATURATE && dn9[8]) ? 8'h00 : dn9[7:0];
    end

    // Write the step result into the pre-edge channel; flag real changes only.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= 8'd0;
            value_g <= 8'd0;
            value_b <= 8'd0;
            updated <= 1'b0;
        end else begin
            updated <= (nxt != cur);
            case (sel)
                SEL_R:   value_r <= nxt;
                SEL_G:   value_g <= nxt;
                SEL_B:   value_b <= nxt;
                default: ;
            endcase
        end
    end

endmodule
